// File: rtl/if_prefetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_prefetch_pkg : shared defaults and helpers for the fetch stage   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package if_prefetch_pkg;

  localparam int          INST_ADDR_W     = 32;
  localparam int          INST_DATA_W     = 32;
  localparam int          FETCH_DEPTH_DEF = 4;
  localparam int          PC_STEP_DEF     = 4;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_prefetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_prefetch_if : ROM request/response and ID handshake bundle       |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface if_prefetch_if
  import if_prefetch_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W,
  parameter int INST_W = INST_DATA_W
);

  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic              rom_ready_i;
  logic              rom_valid_i;
  logic [INST_W-1:0] rom_data_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [INST_W-1:0] id_inst_o;

  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    input  rom_ready_i, rom_valid_i, rom_data_i, redirect_i, redirect_pc_i, id_ready_i
  );

  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o,
    output rom_ready_i, rom_valid_i, rom_data_i, redirect_i, redirect_pc_i, id_ready_i
  );

endinterface
`default_nettype wire

// File: rtl/if_prefetch_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_prefetch_fetch_queue : DEPTH-entry {pc,inst} buffer with         |
// | separate alloc (request), fill (response) and read pointers        |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module if_prefetch_fetch_queue
  import if_prefetch_pkg::*;
#(
  parameter int  ADDR_W = INST_ADDR_W,
  parameter int  INST_W = INST_DATA_W,
  parameter int  DEPTH  = FETCH_DEPTH_DEF,
  localparam int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_pc_i,
  input  logic              fill_i,
  input  logic [INST_W-1:0] fill_inst_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic [INST_W-1:0] head_inst_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [PTR_W-1:0]  inflight_o
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [PTR_W-1:0]  alloc_q, alloc_d;
  logic [PTR_W-1:0]  fill_q, fill_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];

  always_comb begin
    alloc_d = alloc_q + PTR_W'(alloc_i);
    fill_d  = fill_q + PTR_W'(fill_i);
    rd_d    = rd_q + PTR_W'(pop_i);
    if (flush_i) begin
      alloc_d = rd_q;
      fill_d  = rd_q;
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q <= '0;
      fill_q  <= '0;
      rd_q    <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      rd_q    <= rd_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      if (alloc_i && !flush_i) pc_mem_q[alloc_q[IDX_W-1:0]] <= alloc_pc_i;
      if (fill_i && !flush_i)  inst_mem_q[fill_q[IDX_W-1:0]] <= fill_inst_i;
    end
  end

  assign head_pc_o   = pc_mem_q[rd_q[IDX_W-1:0]];
  assign head_inst_o = inst_mem_q[rd_q[IDX_W-1:0]];
  assign empty_o     = (fill_q == rd_q);
  assign full_o      = ((alloc_q - rd_q) == DEPTH_P);
  assign inflight_o  = alloc_q - fill_q;

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_prefetch : prefetching instruction-fetch stage with redirect     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = INST_ADDR_W,
  parameter int                INST_W   = INST_DATA_W,
  parameter int                DEPTH    = FETCH_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int                PC_STEP  = PC_STEP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  if_prefetch_if.master bus
);

  localparam int             PTR_W     = ptr_width(DEPTH);
  localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  drop_q, drop_d;
  logic              run_q;
  logic [PTR_W-1:0]  inflight;
  logic [PTR_W:0]    pending;
  logic [PTR_W:0]    redirect_sub;
  logic              q_empty, q_full;
  logic              issue, live_rsp, drop_rsp, pop;

  // Outstanding = responses still to be discarded plus live requests unfilled.
  assign pending      = {1'b0, drop_q} + {1'b0, inflight};
  assign redirect_sub = (PTR_W+1)'(bus.rom_valid_i && (pending != '0));

  assign bus.rom_ce_o   = run_q & ~bus.redirect_i & ~q_full & (pending < DEPTH_EXT);
  assign bus.rom_addr_o = pc_q;
  assign bus.id_valid_o = ~q_empty & ~bus.redirect_i;

  assign issue    = bus.rom_ce_o & bus.rom_ready_i;
  assign pop      = bus.id_valid_o & bus.id_ready_i;
  assign live_rsp = bus.rom_valid_i & ~bus.redirect_i & (drop_q == '0) & (inflight != '0);
  assign drop_rsp = bus.rom_valid_i & ~bus.redirect_i & (drop_q != '0);

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (bus.redirect_i) begin
      pc_d   = bus.redirect_pc_i;
      drop_d = PTR_W'(pending - redirect_sub);
    end else begin
      if (issue)    pc_d   = pc_q + ADDR_W'(PC_STEP);
      if (drop_rsp) drop_d = drop_q - PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      run_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      run_q  <= 1'b1;
    end
  end

  if_prefetch_fetch_queue #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (issue),
    .alloc_pc_i  (pc_q),
    .fill_i      (live_rsp),
    .fill_inst_i (bus.rom_data_i),
    .pop_i       (pop),
    .flush_i     (bus.redirect_i),
    .head_pc_o   (bus.id_pc_o),
    .head_inst_o (bus.id_inst_o),
    .empty_o     (q_empty),
    .full_o      (q_full),
    .inflight_o  (inflight)
  );

endmodule
`default_nettype wire
